periph_rx_fifo: RTL
===================

Name: periph_rx_fifo

Overview:
- Parametrised successor to the single-word peripheral receiver FSM.
- Accepts words from a processor-side sender over a 4-phase send/ack handshake and buffers them in a DEPTH-entry FIFO.
- Adds backpressure: ack is withheld while the FIFO is full.
- A local consumer drains the FIFO through a show-ahead pop port. Occupancy, full and empty are exported.

Parameters:
- DATA_W, 16: width of the dado word and of rd_data.
- DEPTH, 4: number of FIFO entries. Legal values are 2 and up; power of two is not required.
- CNT_W, $clog2(DEPTH+1): width of count.

Ports:
- clk  input  1  single clock; all flops on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- dado  input  DATA_W  sender data; stable while send=1.
- send  input  1  sender request (4-phase).
- ack  output  1  receiver acknowledge (4-phase), registered.
- rd_en  input  1  consumer pop request.
- rd_data  output  DATA_W  head of FIFO (show-ahead); valid when empty=0.
- empty  output  1  count==0.
- full  output  1  count==DEPTH.
- count  output  CNT_W  current occupancy.

Behaviour:
- Reset (asynchronous, rst=1):
  - State goes to IDLE; ack=0.
  - Write pointer, read pointer and count go to 0, so empty=1 and full=0.
  - rd_data is undefined after reset; FIFO storage is not cleared.
  - A reset mid-handshake drops any in-flight word and returns the block to IDLE.
- The state machine is Moore, two states; ack is decoded from the registered state.
- IDLE (ack=0):
  - If send=1 and full=0: push dado at this edge; next state ACK.
  - If send=1 and full=1: no push; stay in IDLE. The word is pushed on the first edge where full=0.
  - If send=0: stay in IDLE.
- ACK (ack=1):
  - If send=0: next state IDLE.
  - Otherwise stay in ACK. No further push occurs until send has dropped and risen again, so exactly one push happens per handshake.
- Handshake latency with FIFO not full: ack rises 1 cycle after the edge that samples send=1, and falls 1 cycle after the edge that samples send=0.
- Pop:
  - On an edge with rd_en=1 and empty=0, the read pointer advances.
  - rd_data is combinationally the entry at the read pointer.
  - rd_en while empty is ignored; state, pointers and count are unchanged.
- Pointers increment modulo DEPTH, wrapping from DEPTH-1 to 0.
- Count per edge:
  - Push only: +1.
  - Pop only: -1.
  - Push and pop together: unchanged.
- The full check uses the pre-edge count. A pop in the same cycle does not unblock a push; the push waits one more cycle.
- Push and pop in the same cycle are legal whenever 0<count<DEPTH. The popped entry is the old head.
- No overflow or underflow is ever possible; pointers and count never exceed their bounds.

Optional Feature:
- Macro: PERIPH_RX_PARITY_EN.
- When defined, two ports are added:
  - par  input  1: even parity bit accompanying dado.
  - par_err  output  1: sticky flag; reset 0; cleared only by rst.
- The parity check runs at the push edge. If ^{dado,par} is 1:
  - The word is not written; pointers and count are unchanged.
  - The handshake still completes normally (IDLE to ACK).
  - par_err is set to 1.
- When undefined: no par or par_err ports; every accepted word is written.

Test Plan:
- Single transfer: after reset, send=1 with dado=16'hA5A5, held until ack=1, then send=0. Required: ack=1 one cycle after send is sampled high; count=1; empty=0; rd_data=16'hA5A5; ack=0 one cycle after send=0. Then pulse rd_en: count=0, empty=1.
- Fill and backpressure (DEPTH=4): push 1,2,3,4 via four handshakes; full=1, count=4. Fifth send=1 with dado=5: ack stays 0. Pulse rd_en once: rd_data was 1; ack rises 2 cycles after the pop edge; final count=4; pops then return 2,3,4,5.
- Wrap-around: 10 push/pop pairs with dado=0..9, popping each immediately. Required: rd_data sequence 0..9, count never exceeds 1, pointers wrap past index 3 twice.
- Simultaneous push and pop at count=2 (contents 7,8): send accepted in the same cycle as rd_en=1 with dado=9. Required: count stays 2; contents become 8,9.
- Reset mid-operation: rst=1 while in ACK with count=3. Required: ack=0, count=0 and empty=1 immediately (asynchronous); after release with send=0, state is IDLE.
- PERIPH_RX_PARITY_EN defined: dado=16'h0001 with par=0. Required: ack handshake completes, count unchanged, par_err=1 and stays 1 through a subsequent good transfer (dado=16'h0003, par=0), which is written.

Source files
------------

// File: rtl/periph_rx_fifo.sv
// periph_rx_fifo: 4-phase send/ack receiver feeding a DEPTH-entry FIFO.
// The consumer side uses a show-ahead read port.
// Optional build macro: PERIPH_RX_PARITY_EN adds the par input and a sticky par_err output.
// When par_err is enabled, words that fail even parity are dropped, but their handshake still completes.
//
// state | meaning
// IDLE  | ack=0; waiting for send=1 and a free slot, then push
// ACK   | ack=1; word taken, waiting for send=0
module periph_rx_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = $clog2(DEPTH+1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] dado,
  input  logic              send,
  output logic              ack,
`ifdef PERIPH_RX_PARITY_EN
  input  logic              par,
  output logic              par_err,
`endif
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              empty,
  output logic              full,
  output logic [CNT_W-1:0]  count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

  typedef enum logic {IDLE = 1'b0, ACK = 1'b1} state_t;

  state_t            state, state_nxt;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              take;
  logic              par_ok;
  logic              wr;
  logic              pop;

`ifdef PERIPH_RX_PARITY_EN
  assign par_ok = ~(^{dado, par});
`else
  assign par_ok = 1'b1;
`endif

  // Handshake next state and push qualification; full uses the pre-edge count.
  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    case (state)
      IDLE: begin
        if (send && !full) begin
          take      = 1'b1;
          state_nxt = ACK;
        end
      end
      ACK: begin
        if (!send) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign wr      = take && par_ok;
  assign pop     = rd_en && !empty;
  assign ack     = (state == ACK);
  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign rd_data = mem[rd_ptr];

  // State, pointers and occupancy; reset drops any in-flight word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      state <= state_nxt;
      if (wr) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
      if (pop) rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
      if (wr && !pop)      count <= count + 1'b1;
      else if (pop && !wr) count <= count - 1'b1;
    end
  end

  // Storage is intentionally not reset; it is only meaningful while non-empty.
  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= dado;
  end

`ifdef PERIPH_RX_PARITY_EN
  // Sticky parity error; only reset clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  par_err <= 1'b0;
    else if (take && !par_ok) par_err <= 1'b1;
  end
`endif

endmodule
